// File: rtl/common.sv
// Types and constants shared across pipeline stages.
// Holds the PC-select encoding and the decode bubble.
package common;

   typedef enum logic [1:0] {
      PC_NEXT   = 2'b00,
      PC_BRANCH = 2'b01,
      PC_MRET   = 2'b10
   } pc_sel_t;

   // addi x0, x0, 0
   localparam logic [31:0] BUBBLE = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// IF stage: PC generation, credit-limited imem fetch, instruction queue.
// Redirects flush the queue and drop responses still in flight.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] branch_target,
   input  logic [31:0] mret_target,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   import common::*;

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] tag_rd_q, tag_rd_d;
   logic [PW-1:0] tag_wr_q, tag_wr_d;

   logic [31:0] q_pc_q    [FIFO_DEPTH];
   logic [31:0] q_instr_q [FIFO_DEPTH];
   logic [31:0] tag_q     [FIFO_DEPTH];

   pc_sel_t     sel;
   logic        redirect;
   logic [31:0] target;
   logic        credit_ok;
   logic        req_fire;
   logic        drop;
   logic        push;
   logic        pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   assign sel = pc_sel_t'(pc_sel);

   always_comb begin
      redirect = (sel == PC_BRANCH) || (sel == PC_MRET);
      target   = (sel == PC_MRET) ? mret_target : branch_target;
      target   = target & 32'hFFFF_FFFC;

      credit_ok      = ({1'b0, out_cnt_q} + {1'b0, occ_q}) < DEPTH_W;
      imem_req_valid = credit_ok && !redirect && !rst;
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid && imem_req_ready;

      if_valid = (occ_q != '0);
      if_pc    = if_valid ? q_pc_q[rd_ptr_q] : 32'h0;
      if_instr = if_valid ? q_instr_q[rd_ptr_q] : BUBBLE;
      pop      = if_valid && if_ready;

      // Responses owed to an abandoned stream never reach the queue
      drop = imem_resp_valid && (redirect || (discard_q != '0));
      push = imem_resp_valid && !drop;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(imem_resp_valid);
      discard_d  = discard_q;
      occ_d      = occ_q + CW'(push) - CW'(pop);
      rd_ptr_d   = pop ? inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d   = push ? inc(wr_ptr_q) : wr_ptr_q;
      tag_wr_d   = req_fire ? inc(tag_wr_q) : tag_wr_q;
      tag_rd_d   = imem_resp_valid ? inc(tag_rd_q) : tag_rd_q;

      if (req_fire) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (drop && (discard_q != '0)) begin
         discard_d = discard_q - CW'(1);
      end

      // No request fires here, so out_cnt_d is exactly what is still owed
      if (redirect) begin
         fetch_pc_d = target;
         discard_d  = out_cnt_d;
         occ_d      = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_VECTOR;
         out_cnt_q  <= '0;
         discard_q  <= '0;
         occ_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         tag_rd_q   <= '0;
         tag_wr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         out_cnt_q  <= out_cnt_d;
         discard_q  <= discard_d;
         occ_q      <= occ_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
         q_instr_q[wr_ptr_q] <= imem_resp_data;
      end
      if (req_fire) begin
         tag_q[tag_wr_q] <= fetch_pc_q;
      end
   end

endmodule
